// File: rtl/event_fifo_arbiter_if.sv
// Event FIFO write-port bundle: write strobe and data toward the FIFO, and
// fill flags back from the FIFO.
interface event_fifo_arbiter_if;
  logic       fifo_wr_en;
  logic [7:0] fifo_data;
  logic       fifo_full;
  logic       fifo_afull;

  // Arbiter side: drives the write, observes the fill flags.
  modport master (
    output fifo_wr_en,
    output fifo_data,
    input  fifo_full,
    input  fifo_afull
  );

  // FIFO side: accepts the write, reports the fill flags.
  modport slave (
    input  fifo_wr_en,
    input  fifo_data,
    output fifo_full,
    output fifo_afull
  );
endinterface

// File: rtl/event_fifo_arbiter.sv
// event_fifo_arbiter: shares one event-FIFO write port among N_SRC event
// sources. Each source owns a one-entry holding register. A round-robin
// arbiter drains the holding registers at up to one write per cycle, throttled
// by the FIFO full/almost-full flags. An event that finds its holding register
// occupied is dropped, and the drop is recorded in a sticky per-source flag and
// a saturating total counter.
module event_fifo_arbiter #(
  parameter int N_SRC      = 4,
  parameter int DROP_CNT_W = 16
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [N_SRC-1:0]        src_en,
  input  logic [N_SRC-1:0]        ev_valid,
  input  logic [8*N_SRC-1:0]      ev_code,
  output logic [N_SRC-1:0]        pending,
  output logic [N_SRC-1:0]        drop_flag,
  output logic [DROP_CNT_W-1:0]   drop_cnt,
  input  logic                    drop_clr,
  event_fifo_arbiter_if.master    fifo
);

  localparam int LAST_W = $clog2(N_SRC);

  // Population count of a per-source vector. N_SRC <= 8, so 4 bits suffice.
  function automatic logic [3:0] popcount(input logic [N_SRC-1:0] v);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < N_SRC; i++) begin
      cnt = cnt + {3'b000, v[i]};
    end
    return cnt;
  endfunction

  logic [N_SRC-1:0]          hold_v_q, hold_v_d;
  logic [N_SRC-1:0][7:0]     hold_d_q, hold_d_d;
  logic [LAST_W-1:0]         last_q, last_d;
  logic                      wr_en_q, wr_en_d;
  logic [7:0]                data_q, data_d;
  logic [N_SRC-1:0]          drop_flag_q, drop_flag_d;
  logic [DROP_CNT_W-1:0]     drop_cnt_q, drop_cnt_d;

  logic                      can_wr;
  logic                      gnt_any;
  logic [LAST_W-1:0]         gnt_idx;
  logic [N_SRC-1:0]          gnt_vec;
  logic [N_SRC-1:0]          cap_vec;
  logic [N_SRC-1:0]          load_vec;
  logic [N_SRC-1:0]          drop_vec;
  logic [3:0]                ndrop;
  logic [DROP_CNT_W-1:0]     cnt_base;
  logic [DROP_CNT_W:0]       cnt_sum;

  // Round-robin grant: first occupied holding register after the last winner.
  // The almost-full term accounts for the write already in flight, which
  // consumes the last free slot.
  always_comb begin
    int cand;
    can_wr  = !fifo.fifo_full && (!fifo.fifo_afull || !wr_en_q);
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int k = 1; k <= N_SRC; k++) begin
      cand = (int'(last_q) + k) % N_SRC;
      if (can_wr && !gnt_any && hold_v_q[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = LAST_W'(cand);
      end else begin
        gnt_any = gnt_any;
      end
    end
    if (gnt_any) begin
      gnt_vec = N_SRC'(1'b1) << gnt_idx;
    end else begin
      gnt_vec = '0;
    end
  end

  // Capture, drop detection and disable flush for each holding register.
  // A source granted on this edge frees its slot, so a same-edge event loads.
  always_comb begin
    hold_v_d = hold_v_q;
    hold_d_d = hold_d_q;
    cap_vec  = ev_valid & src_en;
    load_vec = cap_vec & (~hold_v_q | gnt_vec);
    drop_vec = cap_vec & hold_v_q & ~gnt_vec;
    for (int i = 0; i < N_SRC; i++) begin
      if (!src_en[i]) begin
        hold_v_d[i] = 1'b0;
      end else if (load_vec[i]) begin
        hold_v_d[i] = 1'b1;
      end else if (gnt_vec[i]) begin
        hold_v_d[i] = 1'b0;
      end else begin
        hold_v_d[i] = hold_v_q[i];
      end
      if (load_vec[i]) begin
        hold_d_d[i] = ev_code[8*i +: 8];
      end else begin
        hold_d_d[i] = hold_d_q[i];
      end
    end
  end

  // FIFO write port and round-robin pointer update; data only moves on grants.
  always_comb begin
    wr_en_d = gnt_any;
    if (gnt_any) begin
      data_d = hold_d_q[gnt_idx];
      last_d = gnt_idx;
    end else begin
      data_d = data_q;
      last_d = last_q;
    end
  end

  // Drop accounting: saturating total plus sticky flags; fresh drops beat clear.
  always_comb begin
    ndrop = popcount(drop_vec);
    if (drop_clr) begin
      cnt_base    = '0;
      drop_flag_d = drop_vec;
    end else begin
      cnt_base    = drop_cnt_q;
      drop_flag_d = drop_flag_q | drop_vec;
    end
    cnt_sum = {1'b0, cnt_base} + (DROP_CNT_W+1)'(ndrop);
    if (cnt_sum[DROP_CNT_W]) begin
      drop_cnt_d = '1;
    end else begin
      drop_cnt_d = cnt_sum[DROP_CNT_W-1:0];
    end
  end

  // State registers with synchronous active-low reset; source 0 wins first.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      hold_v_q    <= '0;
      hold_d_q    <= '0;
      last_q      <= LAST_W'(N_SRC - 1);
      wr_en_q     <= 1'b0;
      data_q      <= 8'h00;
      drop_flag_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      hold_v_q    <= hold_v_d;
      hold_d_q    <= hold_d_d;
      last_q      <= last_d;
      wr_en_q     <= wr_en_d;
      data_q      <= data_d;
      drop_flag_q <= drop_flag_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign fifo.fifo_wr_en = wr_en_q;
  assign fifo.fifo_data  = data_q;
  assign pending         = hold_v_q;
  assign drop_flag       = drop_flag_q;
  assign drop_cnt        = drop_cnt_q;

endmodule

// File: tb/tb_event_fifo_arbiter.sv
// Directed bench for event_fifo_arbiter (N_SRC=4, 4-bit drop counter).
module tb_event_fifo_arbiter;

  logic        aclk;
  logic        aresetn;
  logic [3:0]  src_en;
  logic [3:0]  ev_valid;
  logic [31:0] ev_code;
  logic [3:0]  pending;
  logic [3:0]  drop_flag;
  logic [3:0]  drop_cnt;
  logic        drop_clr;

  int n_checks;
  int n_fail;

  event_fifo_arbiter_if fif ();

  event_fifo_arbiter #(.N_SRC(4), .DROP_CNT_W(4)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .src_en    (src_en),
    .ev_valid  (ev_valid),
    .ev_code   (ev_code),
    .pending   (pending),
    .drop_flag (drop_flag),
    .drop_cnt  (drop_cnt),
    .drop_clr  (drop_clr),
    .fifo      (fif)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic check_wr(input string tag, input logic wr, input logic [7:0] data, input logic [3:0] pend);
    check_val({tag, ".wr_en"},   {31'd0, fif.fifo_wr_en}, {31'd0, wr});
    check_val({tag, ".data"},    {24'd0, fif.fifo_data},  {24'd0, data});
    check_val({tag, ".pending"}, {28'd0, pending},        {28'd0, pend});
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    aresetn        = 1'b0;
    src_en         = 4'hF;
    ev_valid       = 4'h0;
    ev_code        = 32'h0;
    drop_clr       = 1'b0;
    fif.fifo_full  = 1'b0;
    fif.fifo_afull = 1'b0;
    step();
    step();
    check_wr("rst", 1'b0, 8'h00, 4'h0);
    check_val("rst.drop_cnt",  {28'd0, drop_cnt},  32'd0);
    check_val("rst.drop_flag", {28'd0, drop_flag}, 32'd0);
    aresetn = 1'b1;
    step();

    // 1. Fairness: all four strobe together.
    ev_valid = 4'hF; ev_code = 32'h40302010;
    step(); ev_valid = 4'h0;
    check_wr("t1.e0", 1'b0, 8'h00, 4'hF);
    step(); check_wr("t1.e1", 1'b1, 8'h10, 4'hE);
    step(); check_wr("t1.e2", 1'b1, 8'h20, 4'hC);
    step(); check_wr("t1.e3", 1'b1, 8'h30, 4'h8);
    step(); check_wr("t1.e4", 1'b1, 8'h40, 4'h0);
    step(); check_wr("t1.e5", 1'b0, 8'h40, 4'h0);
    check_val("t1.drop_cnt", {28'd0, drop_cnt}, 32'd0);

    // 2. Rotation: last=3, so source 0 before source 3.
    ev_valid = 4'b1001; ev_code = 32'h04000001;
    step(); ev_valid = 4'h0;
    check_wr("t2.e0", 1'b0, 8'h40, 4'h9);
    step(); check_wr("t2.e1", 1'b1, 8'h01, 4'h8);
    step(); check_wr("t2.e2", 1'b1, 8'h04, 4'h0);
    step(); check_wr("t2.e3", 1'b0, 8'h04, 4'h0);

    // 3. Drop while full.
    fif.fifo_full = 1'b1;
    ev_valid = 4'b0100; ev_code = 32'h00A10000;
    step(); ev_code = 32'h00A20000;
    step(); ev_code = 32'h00A30000;
    step(); ev_valid = 4'h0;
    check_wr("t3.full", 1'b0, 8'h04, 4'h4);
    check_val("t3.drop_cnt",  {28'd0, drop_cnt},  32'd2);
    check_val("t3.drop_flag", {28'd0, drop_flag}, 32'h4);
    step(); check_wr("t3.hold", 1'b0, 8'h04, 4'h4);
    fif.fifo_full = 1'b0;
    step(); check_wr("t3.rel", 1'b1, 8'hA1, 4'h0);
    step(); check_wr("t3.idle", 1'b0, 8'hA1, 4'h0);

    // 4. Almost-full alternation, then full blocks; last=2 going in.
    fif.fifo_afull = 1'b1;
    ev_valid = 4'b1011; ev_code = 32'h54005251;
    step(); ev_valid = 4'h0;
    check_wr("t4.e0", 1'b0, 8'hA1, 4'hB);
    step(); check_wr("t4.e1", 1'b1, 8'h54, 4'h3);
    step(); check_wr("t4.e2", 1'b0, 8'h54, 4'h3);
    step(); check_wr("t4.e3", 1'b1, 8'h51, 4'h2);
    step(); check_wr("t4.e4", 1'b0, 8'h51, 4'h2);
    step(); check_wr("t4.e5", 1'b1, 8'h52, 4'h0);
    ev_valid = 4'b1100; ev_code = 32'h74710000;
    step(); ev_valid = 4'h0;
    check_wr("t4.e6", 1'b0, 8'h52, 4'hC);
    step(); check_wr("t4.e7", 1'b1, 8'h71, 4'h8);
    fif.fifo_full = 1'b1;
    step(); check_wr("t4.e8", 1'b0, 8'h71, 4'h8);
    step(); check_wr("t4.e9", 1'b0, 8'h71, 4'h8);
    fif.fifo_full = 1'b0; fif.fifo_afull = 1'b0;
    step(); check_wr("t4.e10", 1'b1, 8'h74, 4'h0);
    step(); check_wr("t4.e11", 1'b0, 8'h74, 4'h0);

    // 5. Saturation (starting from 2) and clear with simultaneous drops.
    fif.fifo_full = 1'b1;
    ev_valid = 4'hF; ev_code = 32'h88776655;
    step(); check_val("t5.s1", {28'd0, drop_cnt}, 32'd2);
    step(); check_val("t5.s2", {28'd0, drop_cnt}, 32'd6);
    step(); check_val("t5.s3", {28'd0, drop_cnt}, 32'd10);
    step(); check_val("t5.s4", {28'd0, drop_cnt}, 32'd14);
    step(); check_val("t5.s5", {28'd0, drop_cnt}, 32'd15);
    step(); check_val("t5.s6", {28'd0, drop_cnt}, 32'd15);
    check_val("t5.flag", {28'd0, drop_flag}, 32'hF);
    ev_valid = 4'b0101; drop_clr = 1'b1;
    step(); ev_valid = 4'h0; drop_clr = 1'b0;
    check_val("t5.clr_cnt",  {28'd0, drop_cnt},  32'd2);
    check_val("t5.clr_flag", {28'd0, drop_flag}, 32'h5);
    step();
    check_val("t5.keep_cnt", {28'd0, drop_cnt}, 32'd2);
    check_wr("t5.full", 1'b0, 8'h74, 4'hF);

    // 6. Disable flush, disabled strobe ignored, then reset.
    src_en = 4'b1101;
    step(); check_wr("t6.flush", 1'b0, 8'h74, 4'hD);
    check_val("t6.flush_cnt", {28'd0, drop_cnt}, 32'd2);
    ev_valid = 4'b0010; ev_code = 32'h00009900;
    step(); ev_valid = 4'h0;
    check_wr("t6.ign", 1'b0, 8'h74, 4'hD);
    check_val("t6.ign_cnt", {28'd0, drop_cnt}, 32'd2);
    fif.fifo_full = 1'b0; aresetn = 1'b0;
    step();
    check_wr("t6.rst", 1'b0, 8'h00, 4'h0);
    check_val("t6.rst_cnt",  {28'd0, drop_cnt},  32'd0);
    check_val("t6.rst_flag", {28'd0, drop_flag}, 32'd0);
    aresetn = 1'b1; src_en = 4'hF;
    for (int i = 0; i < 3; i++) begin
      step(); check_wr("t6.post", 1'b0, 8'h00, 4'h0);
    end

    // Post-reset priority and same-edge capture on a granted source.
    ev_valid = 4'b1001; ev_code = 32'h0C000003;
    step(); ev_code = 32'h00000005; ev_valid = 4'b0001;
    check_wr("t7.e0", 1'b0, 8'h00, 4'h9);
    step(); ev_valid = 4'h0;
    check_wr("t7.e1", 1'b1, 8'h03, 4'h9);
    check_val("t7.nodrop", {28'd0, drop_cnt}, 32'd0);
    step(); check_wr("t7.e2", 1'b1, 8'h0C, 4'h1);
    step(); check_wr("t7.e3", 1'b1, 8'h05, 4'h0);
    step(); check_wr("t7.e4", 1'b0, 8'h05, 4'h0);
    check_val("t7.drop_cnt", {28'd0, drop_cnt}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/event_fifo_arbiter.md
# event_fifo_arbiter

- Shares the single write port of the event FIFO between `N_SRC` event sources.
- Each source has a one-entry holding register; a round-robin arbiter drains the holding registers into the FIFO at one write per cycle, gated by the FIFO fill flags.
- Events that arrive while their source's holding register is occupied are dropped. Drops are counted and flagged for the MMR status block.
- Sits between the timing-receiver event decoders and the event FIFO (`wr_en`/`data_in`).

## Interface

**Parameters**
- `N_SRC`, default 4: number of event sources, 2..8.
- `DROP_CNT_W`, default 16: width of the saturating drop counter.

**Ports**
- `aclk` in 1: clock, all logic on rising edge.
- `aresetn` in 1: synchronous, active-low reset.
- `src_en` in `N_SRC`: per-source enable (quasi-static configuration).
- `ev_valid` in `N_SRC`: single-cycle event strobe per source.
- `ev_code` in `8*N_SRC`: event codes; source i occupies bits [8i+7:8i].
- `fifo_full` in 1: FIFO full flag.
- `fifo_afull` in 1: FIFO almost-full flag, meaning ≤1 free entry.
- `fifo_wr_en` out 1: registered FIFO write enable.
- `fifo_data` out 8: registered FIFO write data.
- `pending` out `N_SRC`: holding-register valid bits.
- `drop_flag` out `N_SRC`: sticky per-source drop indication.
- `drop_cnt` out `DROP_CNT_W`: total dropped events, saturating.
- `drop_clr` in 1: single-cycle clear of `drop_cnt` and `drop_flag`.

## Operation

**Holding registers.** Each source i has `hold_v[i]` and `hold_d[i]`. `pending` = `hold_v`.

**Capture.** On each edge where `ev_valid[i] && src_en[i]`:
- If `hold_v[i]`=0, or source i is granted on this edge: load `hold_d[i]`=`ev_code[i]` and set `hold_v[i]`=1.
- Otherwise: drop the event; the holding register keeps its old content.
- `ev_valid[i]` with `src_en[i]`=0 is ignored and not counted.

**Disable flush.** If `src_en[i]`=0, `hold_v[i]` clears on the next edge. The flushed event is not written and not counted as a drop. A grant already issued on that edge still completes.

**Write permission.** `can_wr` = `!fifo_full && (!fifo_afull || !fifo_wr_en)`. The second term covers the write already in flight, which will take the last free slot.

**Arbitration.**
- Round-robin pointer `last` holds the index of the last granted source.
- When `can_wr` and any `hold_v` is set, grant the first set `hold_v` index searching `last+1, last+2, …` modulo `N_SRC`.
- On a grant edge: `fifo_wr_en`<=1, `fifo_data`<=`hold_d[g]`, `hold_v[g]` cleared (unless reloaded per the capture rule), `last`<=g.
- Otherwise `fifo_wr_en`<=0 and `fifo_data` holds its value.

**Drop accounting.**
- Let `ndrop` = number of sources dropping on this edge.
- `drop_cnt` <= min(all-ones, `drop_cnt` + `ndrop`).
- With `drop_clr`: `drop_cnt` <= `ndrop`, and `drop_flag` <= drop vector of this edge; a new drop wins over the clear.
- Without `drop_clr`: `drop_flag` <= `drop_flag` | drop vector.

**Reset.** All outputs are 0: `fifo_wr_en`, `fifo_data`, `pending`, `drop_flag`, `drop_cnt`. Also `hold_v`=0, `hold_d`=0, and `last`=`N_SRC-1`, so source 0 has first priority. Reset mid-operation discards all held events without counting them.

## Timing

- **Latency:** `ev_valid` sampled at edge E0 → `pending` high after E0 → grant no earlier than E1 → `fifo_wr_en` high in the cycle after E1. Minimum 2 cycles.
- **Throughput:** 1 write per cycle while `fifo_afull`=0.
- **Near-full:** with `fifo_afull`=1 and `fifo_full`=0, at most one write is in flight, so writes alternate with idle cycles.
- **Full:** `fifo_full`=1 means no grants.
- **Starvation bound:** a pending source is written within `N_SRC` grants.
- **Same-cycle capture and grant:** the new code is held; old data goes to the FIFO; no drop.
- **Simultaneous drop and clear:** see Drop accounting; a new drop wins over `drop_clr`.
- **`fifo_data` stability:** changes only on grant edges.

## Test plan

1. **Fairness:** sources 0–3 all strobe codes 0x10,0x20,0x30,0x40 in one cycle, FIFO empty → four consecutive writes 0x10,0x20,0x30,0x40 starting 2 cycles later; `pending` steps 0xF→0xE→0xC→0x8→0x0; `drop_cnt`=0.
2. **Round-robin rotation:** after test 1, sources 0 and 3 strobe 0x01/0x04 simultaneously → 0x01 is written first (`last`=3), then 0x04.
3. **Drop:** `fifo_full`=1, source 2 strobes 0xA1, 0xA2, 0xA3 on consecutive cycles → `hold_d[2]`=0xA1, `drop_cnt`=2, `drop_flag`=0x4. Release full → exactly one write of 0xA1.
4. **Almost-full:** `fifo_afull` held 1, three sources pending → `fifo_wr_en` pattern 1,0,1,0,1 with no back-to-back writes. Asserting `fifo_full` stops writes on the next grant decision.
5. **Clear and saturation:** with `DROP_CNT_W`=4, force 20 drops → `drop_cnt`=0xF. Pulse `drop_clr` in the same cycle as 2 drops → `drop_cnt`=2 and `drop_flag` shows only those 2 sources.
6. **Disable flush and reset:** source 1 pending with `fifo_full`=1, then `src_en[1]`=0 → `pending[1]` clears with no write and no drop. Assert `aresetn`=0 with others pending → all outputs 0 next cycle, and no writes after release.
